branch_predictor: RTL and testbench

//  Dynamic conditional-branch predictor for the 5-stage RV32I core. It holds a table of
//  2-bit saturating counters. Fetch gets a combinational taken/not-taken prediction (br_taken

---
 rtl/branch_predictor_pkg.sv | 30 +++
 rtl/branch_predictor_counter_table.sv | 35 +++
 rtl/branch_predictor.sv | 100 ++++++++++
 tb/tb_branch_predictor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: counter encodings, FSM states, counter helpers.
package branch_predictor_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t BP_SNT      = 2'b00;
    localparam ctr_t BP_WNT      = 2'b01;
    localparam ctr_t BP_WT       = 2'b10;
    localparam ctr_t BP_ST       = 2'b11;
    localparam ctr_t BP_INIT_VAL = BP_WNT;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Saturating step: strongly-taken absorbs further taken, strongly-not-taken absorbs not-taken.
    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        ctr_t nxt;
        if (taken) begin
            nxt = (cur == BP_ST) ? BP_ST : ctr_t'(cur + 2'd1);
        end else begin
            nxt = (cur == BP_SNT) ? BP_SNT : ctr_t'(cur - 2'd1);
        end
        return nxt;
    endfunction

    function automatic logic ctr_predict(input ctr_t cur);
        return cur[1];
    endfunction

endpackage

// File: rtl/branch_predictor_counter_table.sv
// Storage for the 2-bit saturating counters: async read port plus one write port that
// either clears an entry during the init sweep or applies a saturating training update.
module branch_predictor_counter_table
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic                clk,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [1:0]          rd_ctr,
    input  logic                init_en,
    input  logic [IDX_BITS-1:0] init_idx,
    input  logic                upd_en,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_taken
);

    localparam int ENTRIES = 2 ** IDX_BITS;

    ctr_t ctr_mem [ENTRIES];

    // Read returns the value before any same-edge write, so there is no bypass.
    assign rd_ctr = ctr_mem[rd_idx];

    // NOTE: the array has no reset branch; the top's sequential sweep clears it, which keeps
    // it mappable to plain RAM/register-file cells instead of 2^IDX_BITS resettable flops.
    always_ff @(posedge clk) begin
        if (init_en) begin
            ctr_mem[init_idx] <= BP_INIT_VAL;
        end else if (upd_en) begin
            ctr_mem[upd_idx] <= ctr_next(ctr_mem[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic conditional-branch predictor: INIT/RUN sweep FSM, table indexing and, when
// BP_GSHARE_EN is defined, a speculative global history register (gshare indexing).
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = 6,
    parameter int GHR_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         fetch_pc,
    input  logic                fetch_is_br,
    input  logic                stall,
    output logic                pred_taken,
    output logic [IDX_BITS-1:0] pred_idx,
    input  logic                ex_valid,
    input  logic [IDX_BITS-1:0] ex_idx,
    input  logic                ex_taken,
    input  logic                ex_mispred,
    output logic                init_busy
`ifdef BP_GSHARE_EN
    ,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic [GHR_BITS-1:0] ex_ghr
`endif
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = {IDX_BITS{1'b1}};
    localparam bit unused_ghr_fits = (GHR_BITS <= IDX_BITS);

    logic [0:0]          state_q;
    logic [IDX_BITS-1:0] init_cnt;
    logic [IDX_BITS-1:0] fetch_idx;
    logic [1:0]          rd_ctr;
    logic                upd_en;

    assign fetch_idx = fetch_pc[IDX_BITS+1:2];
    assign init_busy = (state_q == ST_INIT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_INIT;
            init_cnt <= '0;
        end else if (state_q == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == LAST_IDX) begin
                state_q <= ST_RUN;
            end
        end
    end

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q;
    logic                unused_gshare;

    assign pred_idx = fetch_idx ^ IDX_BITS'(ghr_q);
    assign pred_ghr = ghr_q;

    // Misprediction repair outranks the same-cycle fetch shift: that fetch is being flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (!init_busy) begin
            if (ex_valid && ex_mispred) begin
                ghr_q <= {ex_ghr[GHR_BITS-2:0], ex_taken};
            end else if (fetch_is_br && !stall) begin
                ghr_q <= {ghr_q[GHR_BITS-2:0], pred_taken};
            end
        end
    end

    assign unused_gshare = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0], ex_ghr[GHR_BITS-1],
                             unused_ghr_fits};
`else
    logic unused_bimodal;

    assign pred_idx = fetch_idx;

    assign unused_bimodal = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0], stall, ex_mispred,
                              unused_ghr_fits};
`endif

    assign pred_taken = !init_busy && fetch_is_br && ctr_predict(rd_ctr);
    assign upd_en     = ex_valid && !init_busy;

    branch_predictor_counter_table #(
        .IDX_BITS(IDX_BITS)
    ) u_table (
        .clk      (clk),
        .rd_idx   (pred_idx),
        .rd_ctr   (rd_ctr),
        .init_en  (init_busy),
        .init_idx (init_cnt),
        .upd_en   (upd_en),
        .upd_idx  (ex_idx),
        .upd_taken(ex_taken)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor (IDX_BITS=6, GHR_BITS=6), hand-computed expectations.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        fetch_is_br;
    logic        stall;
    logic        pred_taken;
    logic [5:0]  pred_idx;
    logic        ex_valid;
    logic [5:0]  ex_idx;
    logic        ex_taken;
    logic        ex_mispred;
    logic        init_busy;
`ifdef BP_GSHARE_EN
    logic [5:0]  pred_ghr;
    logic [5:0]  ex_ghr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_predictor #(
        .IDX_BITS(6),
        .GHR_BITS(6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_pc   (fetch_pc),
        .fetch_is_br(fetch_is_br),
        .stall      (stall),
        .pred_taken (pred_taken),
        .pred_idx   (pred_idx),
        .ex_valid   (ex_valid),
        .ex_idx     (ex_idx),
        .ex_taken   (ex_taken),
        .ex_mispred (ex_mispred),
        .init_busy  (init_busy)
`ifdef BP_GSHARE_EN
        ,
        .pred_ghr   (pred_ghr),
        .ex_ghr     (ex_ghr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic train(input logic [5:0] idx, input logic taken, input int times);
        for (int i = 0; i < times; i++) begin
            ex_valid = 1'b1;
            ex_idx   = idx;
            ex_taken = taken;
            step();
        end
        ex_valid = 1'b0;
    endtask

    task automatic predict(input string tag, input logic [31:0] pc, input logic exp);
        fetch_pc    = pc;
        fetch_is_br = 1'b1;
        #1;
        check(tag, {31'd0, pred_taken}, {31'd0, exp});
        fetch_is_br = 1'b0;
    endtask

    // Releases reset and counts cycles init_busy stays high, bounded.
    task automatic reset_and_sweep(input string tag);
        int busy_cycles;
        rst = 1'b1;
        step();
        rst = 1'b0;
        busy_cycles = 0;
        while (init_busy && busy_cycles < 200) begin
            if (fetch_is_br) begin
                check({tag, "_pred_during_sweep"}, {31'd0, pred_taken}, 32'd0);
            end
            busy_cycles++;
            step();
        end
        check({tag, "_busy_cycles"}, busy_cycles, 32'd64);
    endtask

    initial begin
        rst         = 1'b1;
        fetch_pc    = 32'h0;
        fetch_is_br = 1'b0;
        stall       = 1'b0;
        ex_valid    = 1'b0;
        ex_idx      = 6'd0;
        ex_taken    = 1'b0;
        ex_mispred  = 1'b0;
`ifdef BP_GSHARE_EN
        ex_ghr      = 6'd0;
`endif

        // Reset state, then the 64-cycle sweep with a branch presented throughout.
        step();
        check("reset_init_busy", {31'd0, init_busy}, 32'd1);
        fetch_pc    = 32'h14;
        fetch_is_br = 1'b1;
        #1;
        check("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("reset_pred_idx", {26'd0, pred_idx}, 32'd5);
        reset_and_sweep("sweep1");
        fetch_is_br = 1'b0;
        check("post_sweep_busy", {31'd0, init_busy}, 32'd0);

        // Every entry cleared to WNT -> not taken.
        for (int i = 0; i < 64; i++) begin
            predict($sformatf("clear_pc_%0h", 32'h1000 + 4 * i), 32'h1000 + 4 * i, 1'b0);
        end
        fetch_pc = 32'h10FC;
        #1;
        check("pred_idx_10fc", {26'd0, pred_idx}, 32'd63);

        // idx 5: 01 -T-> 10 -T-> 11
        train(6'd5, 1'b1, 2);
        predict("idx5_t2", 32'h14, 1'b1);
        fetch_pc    = 32'h14;
        #1;
        check("not_branch_no_pred", {31'd0, pred_taken}, 32'd0);
        train(6'd5, 1'b1, 2);
        predict("idx5_sat_st", 32'h14, 1'b1);
        train(6'd5, 1'b0, 1);
        predict("idx5_wt", 32'h14, 1'b1);
        train(6'd5, 1'b0, 1);
        predict("idx5_wnt", 32'h14, 1'b0);
        train(6'd5, 1'b1, 1);
        predict("idx5_wnt_to_wt", 32'h14, 1'b1);
        train(6'd5, 1'b0, 1);
        predict("idx5_back_wnt", 32'h14, 1'b0);

        // idx 9: 01 -NTx3-> 00 (saturated), needs two taken to predict taken.
        train(6'd9, 1'b0, 3);
        predict("idx9_snt", 32'h24, 1'b0);
        train(6'd9, 1'b1, 1);
        predict("idx9_t1", 32'h24, 1'b0);
        train(6'd9, 1'b1, 1);
        predict("idx9_t2", 32'h24, 1'b1);
        predict("idx5_isolated", 32'h14, 1'b0);

        // ex_mispred without ex_valid must not train.
        ex_mispred = 1'b1;
        ex_idx     = 6'd5;
        ex_taken   = 1'b1;
        step();
        ex_mispred = 1'b0;
        predict("mispred_alone", 32'h14, 1'b0);

        // Same-cycle read/write of idx 5 (at 01): old value now, new value next cycle.
        fetch_pc    = 32'h14;
        fetch_is_br = 1'b1;
        ex_valid    = 1'b1;
        ex_idx      = 6'd5;
        ex_taken    = 1'b1;
        #1;
        check("same_cycle_old", {31'd0, pred_taken}, 32'd0);
        step();
        ex_valid = 1'b0;
        #1;
        check("same_cycle_new", {31'd0, pred_taken}, 32'd1);
        fetch_is_br = 1'b0;

        // idx 5 to 11, then re-reset with training attempted throughout the sweep.
        train(6'd5, 1'b1, 1);
        predict("idx5_st_before_rst", 32'h14, 1'b1);
        fetch_pc    = 32'h14;
        fetch_is_br = 1'b1;
        ex_valid    = 1'b1;
        ex_idx      = 6'd5;
        ex_taken    = 1'b1;
        reset_and_sweep("sweep2");
        ex_valid    = 1'b0;
        fetch_is_br = 1'b0;
        predict("idx5_after_rst", 32'h14, 1'b0);
        predict("idx9_after_rst", 32'h24, 1'b0);

`ifdef BP_GSHARE_EN
        // Entries 5 and 4 to ST so pc 0x14 predicts taken under histories 0 and 1.
        train(6'd5, 1'b1, 2);
        train(6'd4, 1'b1, 2);
        fetch_pc    = 32'h14;
        fetch_is_br = 1'b1;
        #1;
        check("ghr_0", {26'd0, pred_ghr}, 32'd0);
        check("ghr_0_pred", {31'd0, pred_taken}, 32'd1);
        step();
        check("ghr_1", {26'd0, pred_ghr}, 32'd1);
        check("ghr_1_pred", {31'd0, pred_taken}, 32'd1);
        step();
        check("ghr_3", {26'd0, pred_ghr}, 32'd3);
        ex_valid   = 1'b1;
        ex_mispred = 1'b1;
        ex_idx     = 6'd20;
        ex_taken   = 1'b0;
        ex_ghr     = 6'h3;
        step();
        ex_valid    = 1'b0;
        ex_mispred  = 1'b0;
        fetch_is_br = 1'b0;
        #1;
        check("ghr_repair", {26'd0, pred_ghr}, 32'h6);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
